// File: rtl/oled_pkg.sv
// Shared OLED controller definitions: SSD1306/SH1106 command bases, FSM states,
// glyph geometry and the byte selector used by the glyph writer.
package oled_pkg;

    localparam logic [7:0] PAGE_BASE = 8'hB0;
    localparam logic [7:0] COL_LO    = 8'h00;
    localparam logic [7:0] COL_HI    = 8'h10;

    localparam int GLYPH_W   = 6;
    localparam int CMD_BYTES = 3;
    localparam logic [3:0] LAST_IDX = 4'(CMD_BYTES + GLYPH_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } oled_state_e;

    // Index 0..2 address the page/column, 3..8 walk the glyph MSB byte first.
    function automatic logic [7:0] glyph_byte(
        input logic [3:0]  idx,
        input logic [2:0]  page,
        input logic [7:0]  col,
        input logic [47:0] data
    );
        logic [7:0] b;
        int         sh;
        b  = 8'h00;
        sh = 0;
        unique case (idx)
            4'd0: b = PAGE_BASE | {5'b0, page};
            4'd1: b = COL_LO | {4'b0, col[3:0]};
            4'd2: b = COL_HI | {4'b0, col[7:4]};
            4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                sh = 8 * (8 - int'(idx));
                b  = data[sh +: 8];
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oled_write_data.sv
// Writes one 6-column glyph to the OLED: page/column address commands followed
// by six data bytes, handshaking each byte with the SPI master.
module oled_write_data
    import oled_pkg::*;
#(
    parameter int COL_OFFSET = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_start,
    input  logic [7:0]  set_pos_x,
    input  logic [7:0]  set_pos_y,
    input  logic [47:0] write_data,
    input  logic        send_done,
    output logic        spi_send,
    output logic [7:0]  spi_data,
    output logic        dc,
    output logic        write_done
);

    oled_state_e state_q;
    logic [3:0]  idx_q;
    logic [6:0]  x_q;
    logic [2:0]  y_q;
    logic [47:0] data_q;
    logic        spi_send_q;
    logic [7:0]  spi_data_q;
    logic        dc_q;
    logic        write_done_q;

    logic [6:0]  src_x;
    logic [2:0]  src_y;
    logic [47:0] src_data;
    logic [3:0]  idx_d;
    logic [7:0]  col_sum;
    logic [7:0]  col;
    logic [7:0]  byte_d;
    logic        unused_ok;

    assign unused_ok = ^{set_pos_x[7], set_pos_y[7:3]};

    // In IDLE the first byte is built straight from the inputs being latched.
    always_comb begin
        src_x    = x_q;
        src_y    = y_q;
        src_data = data_q;
        idx_d    = idx_q + 4'd1;
        if (state_q == IDLE) begin
            src_x    = set_pos_x[6:0];
            src_y    = set_pos_y[2:0];
            src_data = write_data;
            idx_d    = 4'd0;
        end
        col_sum = {1'b0, src_x} + 8'(COL_OFFSET);
        col     = {1'b0, col_sum[6:0]};
        byte_d  = glyph_byte(idx_d, src_y, col, src_data);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            data_q       <= '0;
            spi_send_q   <= 1'b0;
            spi_data_q   <= '0;
            dc_q         <= 1'b0;
            write_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (write_start) begin
                        x_q        <= set_pos_x[6:0];
                        y_q        <= set_pos_y[2:0];
                        data_q     <= write_data;
                        idx_q      <= '0;
                        spi_data_q <= byte_d;
                        dc_q       <= 1'b0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    spi_send_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    spi_send_q <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (send_done) begin
                        if (idx_q < LAST_IDX) begin
                            idx_q      <= idx_d;
                            spi_data_q <= byte_d;
                            dc_q       <= (idx_d >= 4'(CMD_BYTES));
                            state_q    <= LOAD;
                        end else begin
                            write_done_q <= 1'b1;
                            state_q      <= DONE;
                        end
                    end
                end
                DONE: begin
                    write_done_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_send   = spi_send_q;
    assign spi_data   = spi_data_q;
    assign dc         = dc_q;
    assign write_done = write_done_q;

endmodule

// File: tb/tb_oled_write_data.sv
// Scoreboard bench for oled_write_data: expected {dc,byte} pairs are queued by
// the stimulus and popped by a monitor on every spi_send pulse.
module tb_oled_write_data;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_start = 1'b0;
    logic [7:0]  set_pos_x = '0;
    logic [7:0]  set_pos_y = '0;
    logic [47:0] write_data = '0;
    logic        send_done = 1'b0;

    logic        s0_send, s2_send, s0_dc, s2_dc, s0_done, s2_done;
    logic [7:0]  s0_data, s2_data;
    logic        sel = 1'b0;

    logic        spi_send, dc, write_done;
    logic [7:0]  spi_data;

    assign spi_send   = sel ? s2_send : s0_send;
    assign spi_data   = sel ? s2_data : s0_data;
    assign dc         = sel ? s2_dc   : s0_dc;
    assign write_done = sel ? s2_done : s0_done;

    oled_write_data #(.COL_OFFSET(0)) dut0 (
        .clk(clk), .reset(reset), .write_start(write_start),
        .set_pos_x(set_pos_x), .set_pos_y(set_pos_y),
        .write_data(write_data), .send_done(send_done),
        .spi_send(s0_send), .spi_data(s0_data), .dc(s0_dc),
        .write_done(s0_done)
    );

    oled_write_data #(.COL_OFFSET(2)) dut2 (
        .clk(clk), .reset(reset), .write_start(write_start),
        .set_pos_x(set_pos_x), .set_pos_y(set_pos_y),
        .write_data(write_data), .send_done(send_done),
        .spi_send(s2_send), .spi_data(s2_data), .dc(s2_dc),
        .write_done(s2_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    int sends = 0;
    int dones = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    bit gap_chk = 1'b0;
    logic prev_send = 1'b0;

    int spi_delay = 10;
    int long_at = -1;
    bit stray = 1'b0;
    int spi_n = 0;
    int cnt = 0;
    int hold = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push9(input logic [71:0] bytes);
        for (int i = 0; i < 9; i++)
            exp_q.push_back({(i >= 3), bytes[71-8*i -: 8]});
    endtask

    task automatic wait_sends(input int target, input string name);
        int n = 0;
        while (sends < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(sends), 64'(target));
    endtask

    task automatic wait_dones(input int target, input string name);
        int n = 0;
        while (dones < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(dones), 64'(target));
    endtask

    // Monitor: scores every byte handed to the SPI master.
    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        cyc++;
        if (spi_send) begin
            sends++;
            chk("send_pulse_width", 64'(prev_send), 64'(0));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte actual %0h required none",
                         {dc, spi_data});
            end else begin
                e = exp_q.pop_front();
                chk("byte", 64'({dc, spi_data}), 64'(e));
            end
            if (gap_chk) begin
                chk("glyph_gap", 64'(cyc - last_done_cyc), 64'(3));
                gap_chk = 1'b0;
            end
        end
        prev_send = spi_send;
        if (write_done) begin
            dones++;
            last_done_cyc = cyc;
            chk("done_after_all_bytes", 64'(exp_q.size()), 64'(0));
        end
    end

    // SPI master model: send_done a fixed delay after each spi_send.
    always @(posedge clk) begin
        logic sd;
        int d;
        #1;
        sd = 1'b0;
        if (reset) begin
            cnt  = 0;
            hold = 0;
        end else begin
            if (hold > 0) begin
                sd = 1'b1;
                hold--;
            end
            if (spi_send) begin
                spi_n++;
                d   = (spi_n == long_at) ? 50 : spi_delay;
                cnt = d;
                if (stray) sd = 1'b1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    sd = 1'b1;
                    if (stray) hold = 1;
                end
            end
        end
        send_done = sd;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int s0, d0;
        repeat (3) @(negedge clk);
        chk("rst_spi_send", 64'(spi_send), 64'(0));
        chk("rst_spi_data", 64'(spi_data), 64'(0));
        chk("rst_dc", 64'(dc), 64'(0));
        chk("rst_write_done", 64'(write_done), 64'(0));
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_no_send", 64'(sends), 64'(0));

        // Single glyph; write_start drops after the first byte.
        set_pos_x = 8'd60; set_pos_y = 8'd3;
        write_data = 48'h00_63_14_08_14_63;
        push9(72'hB3_0C_13_00_63_14_08_14_63);
        write_start = 1'b1;
        wait_sends(1, "a_first_send");
        write_start = 1'b0;
        wait_dones(1, "a_done");
        repeat (30) @(negedge clk);
        chk("a_single_done", 64'(dones), 64'(1));
        chk("a_send_count", 64'(sends), 64'(9));

        // Back-to-back glyphs with inputs changed on the write_done cycle.
        d0 = dones;
        s0 = sends;
        push9(72'hB3_0C_13_00_63_14_08_14_63);
        write_start = 1'b1;
        wait_dones(d0 + 1, "b1_done");
        set_pos_x = 8'd66;
        write_data = 48'h00_00_41_7F_41_00;
        push9(72'hB3_02_14_00_00_41_7F_41_00);
        gap_chk = 1'b1;
        wait_sends(s0 + 10, "b2_first_send");
        write_start = 1'b0;
        wait_dones(d0 + 2, "b2_done");
        repeat (30) @(negedge clk);
        chk("b_no_third", 64'(dones), 64'(d0 + 2));

        // Column offset 2 with page and column wrap.
        sel = 1'b1;
        d0 = dones;
        s0 = sends;
        set_pos_x = 8'd127; set_pos_y = 8'd9;
        write_data = 48'h3E_51_49_45_3E_00;
        push9(72'hB1_01_10_3E_51_49_45_3E_00);
        write_start = 1'b1;
        wait_sends(s0 + 1, "c_first_send");
        write_start = 1'b0;
        wait_dones(d0 + 1, "c_done");
        repeat (5) @(negedge clk);
        sel = 1'b0;

        // Stray send_done in LOAD/SEND and one slow byte.
        d0 = dones;
        s0 = sends;
        stray = 1'b1;
        long_at = spi_n + 5;
        set_pos_x = 8'd5; set_pos_y = 8'd0;
        write_data = 48'h7F_09_09_09_06_00;
        push9(72'hB0_05_10_7F_09_09_09_06_00);
        write_start = 1'b1;
        wait_sends(s0 + 1, "d_first_send");
        write_start = 1'b0;
        wait_dones(d0 + 1, "d_done");
        repeat (10) @(negedge clk);
        stray = 1'b0;
        chk("d_send_count", 64'(sends - s0), 64'(9));

        // Reset during byte 5, then a fresh glyph.
        d0 = dones;
        s0 = sends;
        set_pos_x = 8'd20; set_pos_y = 8'd2;
        write_data = 48'h18_24_42_24_18_FF;
        push9(72'hB2_04_11_18_24_42_24_18_FF);
        write_start = 1'b1;
        wait_sends(s0 + 5, "e_fifth_send");
        write_start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_spi_send", 64'(spi_send), 64'(0));
        chk("mid_rst_spi_data", 64'(spi_data), 64'(0));
        chk("mid_rst_dc", 64'(dc), 64'(0));
        chk("mid_rst_write_done", 64'(write_done), 64'(0));
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("mid_rst_no_done", 64'(dones), 64'(d0));
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_quiet", 64'(sends), 64'(s0 + 5));
        s0 = sends;
        push9(72'hB2_04_11_18_24_42_24_18_FF);
        write_start = 1'b1;
        wait_sends(s0 + 1, "f_first_send");
        write_start = 1'b0;
        wait_dones(d0 + 1, "f_done");
        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
